cc_rd_wrap_responder: RTL and testbench

Memory-side AXI read responder for the cache controller's line-fill path. It accepts one read request at a time on the AR channel and fetches the addressed 64-byte line from the backing-store read port. It then serializes the line onto the R channel as an 8-beat, 64-bit WRAP burst, critical word first. It is the transmitting end of the R-channel fill stream consumed by the cache data-fill logic.

---
 rtl/cc_rd_wrap_responder.sv | 142 ++++++++++++++
 tb/tb_cc_rd_wrap_responder.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/cc_rd_wrap_responder.sv
// AXI read responder for cache line fills: fetches one 64-byte line per request
// and returns it as an 8-beat 64-bit WRAP burst, critical word first.
module cc_rd_wrap_responder (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         arvalid_i,
  output logic         arready_o,
  input  logic [31:0]  araddr_i,
  input  logic [3:0]   arlen_i,
  input  logic [1:0]   arburst_i,
  output logic         line_rden_o,
  output logic [25:0]  line_raddr_o,
  input  logic [511:0] line_rdata_i,
  output logic         rvalid_o,
  input  logic         rready_i,
  output logic [63:0]  rdata_o,
  output logic [1:0]   rresp_o,
  output logic         rlast_o
);

  localparam int           RLEN      = 8;
  localparam logic [3:0]   LAST_BEAT = 4'(RLEN - 1);
  localparam logic [1:0]   BURST_WRAP = 2'b10;
  localparam logic [1:0]   RESP_OKAY  = 2'b00;
  localparam logic [1:0]   RESP_SLV   = 2'b10;

  typedef enum logic [2:0] {IDLE, FETCH, LOAD, SEND, ERR} state_t;

  state_t       state;
  logic [2:0]   offset;
  logic [3:0]   len;
  logic [3:0]   cnt;
  logic [511:0] line_buf;

  logic [3:0]   cnt_nxt;
  logic [2:0]   widx_nxt;
  logic         beat_hs;
  logic         unused_addr_bits;

  assign cnt_nxt          = cnt + 4'd1;
  // 3-bit sum wraps inside the line, giving the WRAP beat order for free.
  assign widx_nxt         = offset + cnt_nxt[2:0];
  assign beat_hs          = rvalid_o & rready_i;
  assign unused_addr_bits = ^araddr_i[2:0];

  // NOTE: all state uses non-blocking assignments so every register samples
  // the pre-edge values of its neighbours, regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      arready_o    <= 1'b1;
      line_rden_o  <= 1'b0;
      line_raddr_o <= '0;
      rvalid_o     <= 1'b0;
      rdata_o      <= '0;
      rresp_o      <= RESP_OKAY;
      rlast_o      <= 1'b0;
      offset       <= '0;
      len          <= '0;
      cnt          <= '0;
      // NOTE: the line buffer is reset too, so no stale line data can leak
      // out of rdata_o after a reset aborts a burst.
      line_buf     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (arvalid_i) begin
            arready_o    <= 1'b0;
            line_raddr_o <= araddr_i[31:6];
            offset       <= araddr_i[5:3];
            len          <= arlen_i;
            cnt          <= '0;
            if (arlen_i == LAST_BEAT && arburst_i == BURST_WRAP) begin
              state       <= FETCH;
              line_rden_o <= 1'b1;
            end else begin
              // Unsupported request: answer with error beats, no memory access.
              state    <= ERR;
              rvalid_o <= 1'b1;
              rdata_o  <= '0;
              rresp_o  <= RESP_SLV;
              rlast_o  <= (arlen_i == 4'd0);
            end
          end
        end

        FETCH: begin
          line_rden_o <= 1'b0;
          state       <= LOAD;
        end

        LOAD: begin
          // Critical word comes straight from the read port; the buffer fills in parallel.
          line_buf <= line_rdata_i;
          rvalid_o <= 1'b1;
          rdata_o  <= line_rdata_i[{offset, 6'd0} +: 64];
          rresp_o  <= RESP_OKAY;
          rlast_o  <= 1'b0;
          state    <= SEND;
        end

        SEND: begin
          if (beat_hs) begin
            cnt <= cnt_nxt;
            if (rlast_o) begin
              state     <= IDLE;
              rvalid_o  <= 1'b0;
              rlast_o   <= 1'b0;
              arready_o <= 1'b1;
            end else begin
              rdata_o <= line_buf[{widx_nxt, 6'd0} +: 64];
              rlast_o <= (cnt_nxt == LAST_BEAT);
            end
          end
        end

        ERR: begin
          if (beat_hs) begin
            cnt <= cnt_nxt;
            if (rlast_o) begin
              state     <= IDLE;
              rvalid_o  <= 1'b0;
              rlast_o   <= 1'b0;
              rresp_o   <= RESP_OKAY;
              arready_o <= 1'b1;
            end else begin
              rlast_o <= (cnt_nxt == len);
            end
          end
        end

        default: begin
          state     <= IDLE;
          arready_o <= 1'b1;
          rvalid_o  <= 1'b0;
          rlast_o   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cc_rd_wrap_responder.sv
// Directed bench for cc_rd_wrap_responder: a one-cycle-latency line memory model
// plus per-beat checks of order, response, last flag, stall stability and timing.
module tb_cc_rd_wrap_responder;

  logic         clk;
  logic         rst_n;
  logic         arvalid;
  logic         arready;
  logic [31:0]  araddr;
  logic [3:0]   arlen;
  logic [1:0]   arburst;
  logic         line_rden;
  logic [25:0]  line_raddr;
  logic [511:0] line_rdata;
  logic         rvalid;
  logic         rready;
  logic [63:0]  rdata;
  logic [1:0]   rresp;
  logic         rlast;

  logic [511:0] mem_line;
  int           total = 0;
  int           bad   = 0;

  cc_rd_wrap_responder dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .arvalid_i    (arvalid),
    .arready_o    (arready),
    .araddr_i     (araddr),
    .arlen_i      (arlen),
    .arburst_i    (arburst),
    .line_rden_o  (line_rden),
    .line_raddr_o (line_raddr),
    .line_rdata_i (line_rdata),
    .rvalid_o     (rvalid),
    .rready_i     (rready),
    .rdata_o      (rdata),
    .rresp_o      (rresp),
    .rlast_o      (rlast)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Backing store: data valid exactly one cycle after the enable, garbage otherwise.
  always @(posedge clk) begin
    line_rdata <= line_rden ? mem_line : {16{32'hDEAD_BEEF}};
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic fill_line(input logic [63:0] base, input logic [63:0] step);
    for (int k = 0; k < 8; k++) mem_line[64*k +: 64] = base + step * 64'(k);
  endtask

  // Issues one request and consumes its burst. bp selects the 1,0,0,1,0,1 rready
  // pattern; abort_after > 0 returns right after that many beats were accepted.
  task automatic do_burst(input logic [31:0] addr, input logic [3:0] alen,
                          input logic [1:0] aburst, input bit bp, input int abort_after);
    bit          is_err;
    int          nbeats;
    int          beat;
    int          cyc;
    int          rden_seen;
    int          first_valid;
    int          pidx;
    bit          stalled;
    logic [63:0] held_d;
    logic        held_l;
    logic [2:0]  idx;
    logic [63:0] exp_d;
    logic [5:0]  pat;
    is_err      = !(alen == 4'd7 && aburst == 2'b10);
    nbeats      = int'(alen) + 1;
    beat        = 0;
    rden_seen   = 0;
    first_valid = -1;
    pidx        = 0;
    stalled     = 1'b0;
    held_d      = '0;
    held_l      = 1'b0;
    pat         = 6'b101001;

    @(negedge clk);
    check("arready_before_req", 64'(arready), 64'd1);
    arvalid = 1'b1;
    araddr  = addr;
    arlen   = alen;
    arburst = aburst;
    @(negedge clk);
    arvalid = 1'b0;
    cyc     = 1;
    forever begin
      if (line_rden) begin
        rden_seen++;
        check("rden_cycle", 64'(cyc), 64'd1);
        check("line_raddr", 64'(line_raddr), 64'(addr[31:6]));
      end
      if (rvalid) begin
        if (first_valid < 0) begin
          first_valid = cyc;
          check("first_rvalid_cycle", 64'(cyc), is_err ? 64'd1 : 64'd3);
        end
        if (stalled) begin
          check("hold_rdata", rdata, held_d);
          check("hold_rlast", 64'(rlast), 64'(held_l));
        end
        rready = bp ? pat[pidx % 6] : 1'b1;
        pidx++;
        if (rready) begin
          idx   = addr[5:3] + 3'(beat);
          exp_d = is_err ? 64'd0 : mem_line[64*idx +: 64];
          check("rdata", rdata, exp_d);
          check("rresp", 64'(rresp), is_err ? 64'd2 : 64'd0);
          check("rlast", 64'(rlast), 64'(beat == nbeats - 1));
          beat++;
          stalled = 1'b0;
        end else begin
          stalled = 1'b1;
          held_d  = rdata;
          held_l  = rlast;
        end
      end else begin
        rready = 1'b0;
      end
      @(negedge clk);
      cyc++;
      if (beat == nbeats || (abort_after > 0 && beat == abort_after) || cyc >= 200) break;
    end
    if (cyc >= 200) check("burst_timeout", 64'd1, 64'd0);
    if (abort_after == 0) begin
      rready = 1'b0;
      check("rvalid_after_last", 64'(rvalid), 64'd0);
      check("arready_after_last", 64'(arready), 64'd1);
      check("rden_count", 64'(rden_seen), is_err ? 64'd0 : 64'd1);
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    arvalid  = 1'b0;
    araddr   = '0;
    arlen    = '0;
    arburst  = '0;
    rready   = 1'b0;
    mem_line = '0;
    fill_line(64'd0, 64'h1111_1111_1111_1111);

    // Reset then idle.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_arready", 64'(arready), 64'd1);
    check("rst_rvalid", 64'(rvalid), 64'd0);
    check("rst_rlast", 64'(rlast), 64'd0);
    check("rst_rresp", 64'(rresp), 64'd0);
    check("rst_rdata", rdata, 64'd0);
    check("rst_rden", 64'(line_rden), 64'd0);
    check("rst_raddr", 64'(line_raddr), 64'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle_rvalid", 64'(rvalid), 64'd0);
      check("idle_rden", 64'(line_rden), 64'd0);
      check("idle_arready", 64'(arready), 64'd1);
    end

    // Aligned burst, critical-word wrap, backpressure.
    do_burst(32'h0000_1240, 4'd7, 2'b10, 1'b0, 0);
    do_burst(32'h0000_1268, 4'd7, 2'b10, 1'b0, 0);
    do_burst(32'h0000_3398, 4'd7, 2'b10, 1'b1, 0);

    // Unsupported requests: short INCR, single beat, and a 16-beat error burst.
    do_burst(32'h0000_2000, 4'd3, 2'b01, 1'b0, 0);
    do_burst(32'h0000_2040, 4'd0, 2'b10, 1'b1, 0);
    do_burst(32'h0000_2080, 4'd15, 2'b00, 1'b0, 0);
    do_burst(32'h0000_20C0, 4'd7, 2'b01, 1'b0, 0);

    // Reset mid-burst, then a fresh fetch of a different line pattern.
    do_burst(32'h0000_1240, 4'd7, 2'b10, 1'b0, 3);
    rst_n  = 1'b0;
    rready = 1'b0;
    #1;
    check("abort_rvalid", 64'(rvalid), 64'd0);
    check("abort_arready", 64'(arready), 64'd1);
    check("abort_rlast", 64'(rlast), 64'd0);
    check("abort_rdata", rdata, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    fill_line(64'hA5A5_0000_0000_00A0, 64'h0000_0001_0000_0001);
    do_burst(32'h0000_1240, 4'd7, 2'b10, 1'b0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
